pong_score_reporter: RTL
========================

PONG_SCORE_REPORTER -- requirements
Module: pong_score_reporter

Interface
REQ-001 The module SHALL have parameter SCORE_WIN, default 9, giving the score that wins the game.
REQ-002 The module SHALL have port i_clk, input, 1 bit, the single system clock (25 MHz).
REQ-003 The module SHALL have port i_reset, input, 1 bit, a synchronous active-high reset sampled on the rising edge of i_clk.
REQ-004 The module SHALL have port i_score_1, input, 4 bits, the player 1 score.
REQ-005 The module SHALL have port i_score_2, input, 4 bits, the player 2 score.
REQ-006 The module SHALL have port i_game_over, input, 1 bit, a level that is high while the game is over.
REQ-007 The module SHALL have port i_tx_active, input, 1 bit, the UART transmitter busy flag.
REQ-008 The module SHALL have port i_tx_done, input, 1 bit, a one-cycle pulse from the UART transmitter when a byte has been sent.
REQ-009 The module SHALL have port o_tx_dv, output, 1 bit, a one-cycle pulse that loads o_tx_byte into the UART transmitter.
REQ-010 The module SHALL have port o_tx_byte, output, 8 bits, the byte to transmit.
REQ-011 The module SHALL have port o_busy, output, 1 bit, which is high while a message is in progress.

Function
REQ-012 The module SHALL keep a snapshot of the last reported pair of scores, held in two 4-bit registers.
REQ-013 A score message SHALL be pending whenever {i_score_1, i_score_2} differs from the snapshot while the state is IDLE.
REQ-014 The score message SHALL be exactly 6 bytes, in this order: 'S' (0x53), digit(score_1), ':' (0x3A), digit(score_2), CR (0x0D), LF (0x0A).
REQ-015 The digit encoding SHALL map values 0-9 to 0x30-0x39 and values 10-15 to 'A'-'F' (0x41-0x46).
REQ-016 The snapshot SHALL be loaded from the inputs in the cycle the message starts, and every digit byte SHALL come from the snapshot, never from the live inputs.
REQ-017 The state machine SHALL have the states IDLE, SEND, WAIT_DONE and NEXT.
REQ-018 In IDLE, when a message is pending and i_tx_active=0, the machine SHALL clear the byte index to 0 and move to SEND on the next edge.
REQ-019 In SEND, the machine SHALL drive o_tx_dv=1 for exactly one cycle with o_tx_byte set to the byte at the current index, then move to WAIT_DONE.
REQ-020 In WAIT_DONE, the machine SHALL stay until i_tx_done=1, then move to NEXT.
REQ-021 In NEXT, the machine SHALL go to SEND with the index incremented if bytes remain; otherwise it SHALL go to IDLE.
REQ-022 o_tx_dv SHALL never be asserted while i_tx_active=1, and SHALL be asserted at most once per i_tx_done pulse.
REQ-023 If the scores change during a message, the current message SHALL complete unchanged, and a new message SHALL start from IDLE afterwards.
REQ-024 Several score changes during one message SHALL produce only one follow-up message, carrying the latest values.
REQ-025 o_busy SHALL be high in SEND, WAIT_DONE and NEXT, and low in IDLE.
REQ-026 Latency from a score change seen in IDLE (with i_tx_active=0) to the first o_tx_dv pulse SHALL be 2 cycles.
REQ-027 o_tx_byte SHALL hold its last value when o_tx_dv=0.

Reset
REQ-028 When i_reset=1, the module SHALL on that edge set: state=IDLE, o_tx_dv=0, o_tx_byte=0x00, o_busy=0, snapshot=0/0, index=0, game-over edge register=0.
REQ-029 A reset asserted in the middle of a message SHALL abort the message at once, with no further o_tx_dv pulse.
REQ-030 After reset, if the inputs are non-zero, a message SHALL be sent on the following IDLE evaluation.

Configuration
REQ-031 When the macro PONG_REPORT_WINNER_EN is defined, a rising edge of i_game_over SHALL set a winner-pending flag.
REQ-032 With PONG_REPORT_WINNER_EN defined, when no score message is pending, the module SHALL send the 4-byte winner message 'W', winner, CR, LF.
REQ-033 The winner byte SHALL be '1' if snapshot score_1==SCORE_WIN, '2' if snapshot score_2==SCORE_WIN, and '0' otherwise.
REQ-034 A score message SHALL always take priority over a winner message.
REQ-035 The winner-pending flag SHALL be cleared when the winner message starts.
REQ-036 Without PONG_REPORT_WINNER_EN, i_game_over SHALL be ignored and only score messages SHALL exist.

Verification
REQ-037 Scenario: reset, then i_score_1=3, i_score_2=0, with an ideal transmitter model (i_tx_done 10 cycles after o_tx_dv) -> bytes 53 33 3A 30 0D 0A, o_busy low after the last i_tx_done.
REQ-038 Scenario: i_score_2 changes 1->2->4 during byte 2 of a message -> the first message is unchanged, then exactly one follow-up message with digit '4'.
REQ-039 Scenario: i_score_1=12 -> digit byte 0x43 ('C').
REQ-040 Scenario: i_tx_active held at 1 while the scores change -> no o_tx_dv until i_tx_active=0, then the first pulse 2 cycles later.
REQ-041 Scenario: i_reset pulse during WAIT_DONE of byte 3 -> no further o_tx_dv, all outputs at reset values; with scores 0/0, no message follows.
REQ-042 Scenario: with PONG_REPORT_WINNER_EN defined, i_score_1 goes 8->9 and i_game_over rises in the same cycle -> message 'S9:x' CR LF, then 57 31 0D 0A.

Source files
------------

// File: rtl/pong_score_reporter.sv
// pong_score_reporter: sends the Pong score to a byte-wide UART transmitter
// as "S<d1>:<d2>\r\n" whenever the score pair changes.
// Optional build macro: PONG_REPORT_WINNER_EN. When it is defined, a rising
// edge of i_game_over also queues a "W<winner>\r\n" message.
module pong_score_reporter #(
  parameter int unsigned SCORE_WIN = 9
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_score_1,
  input  logic [3:0] i_score_2,
  input  logic       i_game_over,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  output logic       o_busy
);

  localparam logic [7:0] CHAR_S  = 8'h53;
  localparam logic [7:0] CHAR_CO = 8'h3A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, NEXT} state_t;

  state_t     state;
  logic [3:0] snap_1;
  logic [3:0] snap_2;
  logic [2:0] byte_idx;
  logic [2:0] last_idx;
  logic [7:0] cur_byte;
  logic       score_pending;

`ifdef PONG_REPORT_WINNER_EN
  localparam logic [3:0] WIN_SCORE = SCORE_WIN[3:0];
  localparam logic [7:0] CHAR_W    = 8'h57;

  logic       game_over_q;
  logic       winner_pending;
  logic       msg_winner;
  logic [7:0] winner_char;
`else
  // The game-over level has no effect in this build.
  logic unused_game_over;
  assign unused_game_over = i_game_over;
`endif

  // ASCII hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  function automatic logic [7:0] hex_digit(input logic [3:0] value);
    if (value < 4'd10) return 8'h30 + {4'h0, value};
    else               return 8'h37 + {4'h0, value};
  endfunction

  assign score_pending = ({i_score_1, i_score_2} != {snap_1, snap_2});

`ifdef PONG_REPORT_WINNER_EN
  // Winner is decided from the last reported score, not the live inputs.
  always_comb begin
    winner_char = 8'h30;
    if (snap_1 == WIN_SCORE)      winner_char = 8'h31;
    else if (snap_2 == WIN_SCORE) winner_char = 8'h32;
  end
`endif

  // Select the byte at the current index of the active message.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    cur_byte = 8'h00;
    last_idx = 3'd5;
`ifdef PONG_REPORT_WINNER_EN
    if (msg_winner) begin
      last_idx = 3'd3;
      case (byte_idx)
        3'd0:    cur_byte = CHAR_W;
        3'd1:    cur_byte = winner_char;
        3'd2:    cur_byte = CHAR_CR;
        3'd3:    cur_byte = CHAR_LF;
        default: cur_byte = 8'h00;
      endcase
    end else begin
`else
    begin
`endif
      case (byte_idx)
        3'd0:    cur_byte = CHAR_S;
        3'd1:    cur_byte = hex_digit(snap_1);
        3'd2:    cur_byte = CHAR_CO;
        3'd3:    cur_byte = hex_digit(snap_2);
        3'd4:    cur_byte = CHAR_CR;
        3'd5:    cur_byte = CHAR_LF;
        default: cur_byte = 8'h00;
      endcase
    end
  end

  // Message sequencer: start on a change, hand bytes to the UART one at a
  // time, wait for each completion before moving on.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    if (i_reset) begin
      state     <= IDLE;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_busy    <= 1'b0;
      snap_1    <= 4'h0;
      snap_2    <= 4'h0;
      byte_idx  <= 3'd0;
`ifdef PONG_REPORT_WINNER_EN
      game_over_q    <= 1'b0;
      winner_pending <= 1'b0;
      msg_winner     <= 1'b0;
`endif
    end else begin
      o_tx_dv <= 1'b0;
`ifdef PONG_REPORT_WINNER_EN
      game_over_q <= i_game_over;
`endif
      case (state)
        IDLE: begin
          if (!i_tx_active && score_pending) begin
            snap_1   <= i_score_1;
            snap_2   <= i_score_2;
            byte_idx <= 3'd0;
            o_busy   <= 1'b1;
            state    <= SEND;
`ifdef PONG_REPORT_WINNER_EN
            msg_winner <= 1'b0;
`endif
          end
`ifdef PONG_REPORT_WINNER_EN
          else if (!i_tx_active && winner_pending) begin
            winner_pending <= 1'b0;
            msg_winner     <= 1'b1;
            byte_idx       <= 3'd0;
            o_busy         <= 1'b1;
            state          <= SEND;
          end
`endif
        end
        SEND: begin
          // Never load the transmitter while it still reports busy.
          if (!i_tx_active) begin
            o_tx_dv   <= 1'b1;
            o_tx_byte <= cur_byte;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) state <= NEXT;
        end
        NEXT: begin
          if (byte_idx == last_idx) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SEND;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
`ifdef PONG_REPORT_WINNER_EN
      // A new game-over edge wins over a same-cycle clear.
      if (i_game_over && !game_over_q) winner_pending <= 1'b1;
`endif
    end
  end

endmodule
